// File: rtl/led_test_pkg.sv
// rtl/led_test_pkg.sv - shared types, constants and golden LED function for the self-test
package led_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 16;

    // Golden response of the lab-1 LED logic for one switch setting.
    function automatic logic [1:0] led_expected(input logic [3:0] s);
        return {s[3] & s[2], s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// rtl/led_dwell_timer.sv - counts DWELL cycles per vector and flags the last one
module led_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);

    // A 1-bit counter is kept even for DWELL=1 so the compare stays well formed.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == LAST);

    // Count 0..DWELL-1 while enabled, wrapping so the next vector starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_selftest_seq.sv
// rtl/led_selftest_seq.sv - exhaustive switch-vector sequencer and checker for the LED logic
module led_selftest_seq
    import led_test_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int ERR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [3:0]       s_out,
    input  logic [1:0]       led_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] errors,
    output logic [3:0]       first_fail
);

    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [ERR_W-1:0] errors_q, errors_d;
    logic [3:0]       ff_q, ff_d;
    logic             busy_q, done_q;
    logic             tmr_clear, tmr_en, tmr_expire;
    logic [1:0]       exp_led;
    logic             mismatch;

    led_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // Case-inequality so an undriven or X response is scored as a failure.
    assign exp_led  = led_expected(vec_q);
    assign mismatch = (led_in !== exp_led);

    // Next-state, vector stepping and result accumulation.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        errors_d  = errors_q;
        ff_d      = ff_q;
        tmr_en    = (state_q == RUN);
        tmr_clear = (state_q != RUN);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = 4'd0;
                    errors_d = '0;
                    ff_d     = 4'd0;
                end
            end
            RUN: begin
                if (tmr_expire) begin
                    if (mismatch) begin
                        if (errors_q == '0) begin
                            ff_d = vec_q;
                        end
                        if (errors_q != '1) begin
                            errors_d = errors_q + 1'b1;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= 4'd0;
            errors_q <= '0;
            ff_q     <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            errors_q <= errors_d;
            ff_q     <= ff_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign s_out      = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign errors     = errors_q;
    assign first_fail = ff_q;
    assign pass       = done_q && (errors_q == '0);

endmodule

// File: tb/tb_led_selftest_seq.sv
// tb/tb_led_selftest_seq.sv - directed self-checking bench for led_selftest_seq
module tb_led_selftest_seq;
    import led_test_pkg::*;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    int         mode;

    logic [3:0] s_out, first_fail;
    logic [1:0] led_in;
    logic       busy, done, pass;
    logic [4:0] errors;

    logic [3:0] s_out3, first_fail3;
    logic [1:0] led_in3;
    logic       busy3, done3, pass3;
    logic [2:0] errors3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    // Mode 0 good LED logic, 1 bit0 stuck at 0, 2 bit1 inverted.
    function automatic logic [1:0] led_model(input logic [3:0] s, input int m);
        logic [1:0] r;
        r = led_expected(s);
        if (m == 1) r[0] = 1'b0;
        if (m == 2) r[1] = ~r[1];
        return r;
    endfunction

    always_comb led_in  = led_model(s_out, mode);
    always_comb led_in3 = led_model(s_out3, mode);

    led_selftest_seq #(.DWELL(DW), .ERR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_out      (s_out),
        .led_in     (led_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .errors     (errors),
        .first_fail (first_fail)
    );

    led_selftest_seq #(.DWELL(DW), .ERR_W(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_out      (s_out3),
        .led_in     (led_in3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .errors     (errors3),
        .first_fail (first_fail3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_s_out"}, s_out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_errors"}, errors, 0);
        check_eq({tag, "_first_fail"}, first_fail, 0);
    endtask

    // Pulse start, optionally pulse it again mid-run, and wait for done.
    task automatic run_test(input bit chk_sout, input int mid_vec, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("e0_busy", busy, 1);
        check_eq("e0_s_out", s_out, 0);
        check_eq("e0_errors", errors, 0);
        check_eq("e0_first_fail", first_fail, 0);
        check_eq("e0_done", done, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (mid_vec >= 0 && cycles == mid_vec * DW + 1);
            if (chk_sout && done !== 1'b1)
                check_eq($sformatf("s_out_c%0d", cycles), s_out, cycles / DW);
        end
        start = 1'b0;
        check_eq("run_cycles", cycles, 64);
        check_eq("end_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        #3;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Good DUT: clean run, full stimulus sweep.
        mode = 0;
        run_test(1'b1, -1, cyc);
        check_eq("good_errors", errors, 0);
        check_eq("good_pass", pass, 1);
        check_eq("good_first_fail", first_fail, 0);
        check_eq("good_pass3", pass3, 1);

        // Bit1 inverted: every vector fails; narrow counter saturates.
        mode = 2;
        run_test(1'b0, -1, cyc);
        check_eq("inv_errors", errors, 16);
        check_eq("inv_errors3", errors3, 7);
        check_eq("inv_first_fail3", first_fail3, 0);
        check_eq("inv_pass3", pass3, 0);
        check_eq("inv_done3", done3, 1);

        // Bit0 stuck at 0: vectors 1,2,5,6,9,10,13,14 fail.
        mode = 1;
        run_test(1'b0, -1, cyc);
        check_eq("stuck_errors", errors, 8);
        check_eq("stuck_first_fail", first_fail, 1);
        check_eq("stuck_pass", pass, 0);
        check_eq("stuck_errors3", errors3, 7);

        // Rerun from DONE with good DUT, start pulsed during vector 5.
        mode = 0;
        run_test(1'b1, 5, cyc);
        check_eq("rerun_errors", errors, 0);
        check_eq("rerun_first_fail", first_fail, 0);
        check_eq("rerun_pass", pass, 1);

        // Asynchronous reset mid-run at vector 9.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 37) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("pre_rst_s_out", s_out, 9);
        check_eq("pre_rst_errors", errors, 4);
        check_eq("pre_rst_first_fail", first_fail, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        reset = 1'b0;
        mode = 0;
        run_test(1'b0, -1, cyc);
        check_eq("post_rst_pass", pass, 1);
        check_eq("post_rst_errors", errors, 0);

        // Start held high: one DONE cycle, then a new run begins.
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (done !== 1'b1 && cyc < 200);
        check_eq("loop_first_done", cyc, 65);
        @(posedge clk);
        #1;
        check_eq("loop_restart_busy", busy, 1);
        check_eq("loop_restart_done", done, 0);
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_selftest_seq.md
# led_selftest_seq

On-board self-test sequencer for the lab-1 switch/LED logic. It drives the 4-bit switch bus `s` into the LED logic exhaustively (0 to 15) and reads the LED outputs back. Each response is compared against a built-in golden function, and the sequencer reports an error count, the first failing vector, and pass/fail. It sits between the top level and the `led1` logic as a synthesizable in-hardware counterpart to the vector-based bench: it generates stimulus and checks the response.

## Interface
Parameters:
- `DWELL`, default 4: cycles each vector is held; must be at least 1.
- `ERR_W`, default 5: width of the error counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled on each rising edge; acted on only in IDLE or DONE.
- `s_out`  out  4  switch stimulus to the DUT.
- `led_in`  in  2  DUT LED response; bits [1:0] are checked.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  high from end of run until the next start or reset.
- `pass`  out  1  `done && errors == 0`.
- `errors`  out  ERR_W  count of failing vectors; saturates at all-ones.
- `first_fail`  out  4  index of the first failing vector; 0 if none.

## Operation
- Golden function:
  - exp[0] = s[1] ^ s[0]
  - exp[1] = s[3] & s[2]
  - A vector fails if `led_in !== exp` on either bit; X or Z counts as a mismatch in simulation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start` moves to RUN. Entering RUN sets vec=0 and dwell=0, and clears `errors` and `first_fail`.
  - RUN: `s_out` = vec. dwell counts 0 to DWELL-1.
  - RUN, on the edge where dwell == DWELL-1: compare `led_in` with exp(vec) and update `errors`/`first_fail`.
    - If vec == 15, go to DONE.
    - Otherwise vec+1 and dwell=0.
  - DONE: results are held. `start` re-enters RUN with cleared results.
- `start` during RUN is ignored.
- `first_fail` is written only on the first failure, i.e. while `errors` == 0.
- `errors` increments by 1 per failing vector and stops at 2^ERR_W-1; it never wraps.
- vec is 4 bits, and the last vector is 15; vec never wraps to 0 inside a run.

## Timing
- Reset values, applied immediately (asynchronous):
  - state IDLE, `s_out`=0, `busy`=0, `done`=0, `pass`=0, `errors`=0, `first_fail`=0, vec=0, dwell=0.
- Reset during RUN or DONE aborts to IDLE with the values above. No partial results are retained.
- All outputs are registered. `pass` may be combinational from `done` and `errors`.
- Let E0 be the edge where `start` is sampled high.
  - After E0, `busy`=1 and `s_out`=0.
  - Vector k is driven after edge E(k·DWELL) and compared at edge E((k+1)·DWELL).
  - After edge E(16·DWELL), `busy`=0 and `done`=1. With DWELL=4 that is 64 cycles.
- The DUT response must settle within DWELL-1 cycles of `s_out` changing. With DWELL=1, the sample comes one edge after the drive.
- Simultaneous events:
  - The final compare and the DONE transition happen on the same edge. The final vector's error is included in the `errors` value that `done` exposes.
  - `start` held high in DONE restarts on the next edge. A continuously high `start` therefore loops runs, with one DONE cycle between them.

## Structure
- Package `led_test_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DONE);
  - the constant `NUM_VEC`=16;
  - the function `led_expected(logic [3:0] s)` returning logic [1:0]. The bench uses the same function.
- Sub-module `led_dwell_timer`: DWELL-cycle counter with `clear` input and `expire` output, reset to 0.
- Top module: FSM, vector counter, compare, and result registers.

## Test plan
- Golden DUT (a model of `led_expected`), DWELL=4:
  - `done` rises 64 cycles after E0.
  - `errors`=0, `pass`=1, `first_fail`=0.
  - `s_out` steps 0 to 15, each value held 4 cycles.
- `led_in[0]` stuck at 0:
  - Fails on vectors 1, 2, 5, 6, 9, 10, 13, 14.
  - `errors`=8, `first_fail`=1, `pass`=0.
- `led_in[1]` inverted, with ERR_W=3:
  - 16 raw failures; `errors` saturates at 7.
  - `first_fail`=0, `pass`=0.
- `start` pulsed mid-RUN at vector 5: ignored, and `done` still rises at cycle 64.
- Re-running from DONE with a good DUT: `errors` and `first_fail` clear on entering RUN, and the run ends with `pass`=1.
- `reset` asserted asynchronously (between clock edges) at vector 9:
  - All outputs return to reset values immediately.
  - A subsequent `start` gives a full, correct run.
